serial_adder_n: RTL and testbench



---
 rtl/serial_adder_n_if.sv | 27 ++
 rtl/serial_adder_n.sv | 107 ++++++++++
 tb/tb_serial_adder_n.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_n_if.sv
// Operand/result handshake bundle for serial_adder_n.
// The adder takes the slave side; the producer/consumer takes the master side.
interface serial_adder_n_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder_n.sv
// Multi-cycle adder/subtractor: BITS_PER_CYCLE bits per clock, LSB slice first,
// registered carry between slices, valid/ready on both sides.
module serial_adder_n #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input logic             clk,
    input logic             rst_n,
    serial_adder_n_if.slave bus
);
    localparam int unsigned B      = (BITS_PER_CYCLE == 0) ? 1 : BITS_PER_CYCLE;
    localparam int unsigned NSLICE = WIDTH / B;
    localparam int unsigned CNTW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    generate
        if (WIDTH < 2 || BITS_PER_CYCLE == 0 || (WIDTH % B) != 0) begin : g_bad_params
            $error("serial_adder_n: WIDTH must be >= 2 and divisible by BITS_PER_CYCLE");
        end
    endgenerate

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;   // b already inverted for subtraction
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    int unsigned       slice_lo;
    logic [B:0]        slice_res;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        slice_lo  = int'(cnt_q) * B;
        slice_res = {1'b0, a_q[slice_lo +: B]} + {1'b0, b_q[slice_lo +: B]}
                  + {{B{1'b0}}, carry_q};

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? ~bus.cin : bus.cin;
                    sum_d   = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[slice_lo +: B] = slice_res[B-1:0];
                carry_d              = slice_res[B];
                cnt_d                = cnt_q + CNTW'(1);
                if (cnt_q == CNTW'(NSLICE - 1)) begin
                    // Last slice holds the MSB, so its result bit is the final sum sign.
                    cout_d  = slice_res[B];
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_res[B-1] != a_q[WIDTH-1]);
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle) && rst_n;
    assign bus.out_valid = (state_q == StDone);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_serial_adder_n.sv
// Directed and exhaustive checks of serial_adder_n: 8-bit B=1 instance plus
// 4-bit instances with 1, 2 and 4 bits per cycle.
module tb_serial_adder_n;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    serial_adder_n_if #(.WIDTH(8)) bus8 ();
    serial_adder_n_if #(.WIDTH(4)) bus41 ();
    serial_adder_n_if #(.WIDTH(4)) bus42 ();
    serial_adder_n_if #(.WIDTH(4)) bus44 ();

    serial_adder_n #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_adder_n #(.WIDTH(4), .BITS_PER_CYCLE(1)) dut41 (.clk(clk), .rst_n(rst_n), .bus(bus41));
    serial_adder_n #(.WIDTH(4), .BITS_PER_CYCLE(2)) dut42 (.clk(clk), .rst_n(rst_n), .bus(bus42));
    serial_adder_n #(.WIDTH(4), .BITS_PER_CYCLE(4)) dut44 (.clk(clk), .rst_n(rst_n), .bus(bus44));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} from signed/unsigned integer arithmetic.
    function automatic logic [5:0] ref4(input logic [3:0] a, input logic [3:0] b,
                                        input logic cin, input logic sub);
        int sa, sb, sr, ua, ub, ur;
        logic c, o;
        ua = int'(a);
        ub = int'(b);
        sa = a[3] ? ua - 16 : ua;
        sb = b[3] ? ub - 16 : ub;
        if (sub) begin
            ur = ua - ub - int'(cin);
            sr = sa - sb - int'(cin);
            c  = (ua >= ub + int'(cin));
        end else begin
            ur = ua + ub + int'(cin);
            sr = sa + sb + int'(cin);
            c  = (ur >= 16);
        end
        o = (sr > 7) || (sr < -8);
        return {o, c, 4'(ur)};
    endfunction

    // Called at a negedge with the 8-bit DUT idle; junk is driven during RUN.
    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic sub, input logic [7:0] es,
                       input logic ec, input logic eo, input bit release_it);
        int lat;
        chk({tag, ".in_ready"}, 32'(bus8.in_ready), 32'd1);
        bus8.in_valid = 1'b1;
        bus8.a = a;
        bus8.b = b;
        bus8.cin = cin;
        bus8.sub = sub;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        lat = 0;
        while (!bus8.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            bus8.in_valid = lat[0];
            bus8.a = 8'($urandom);
            bus8.b = 8'($urandom);
            bus8.cin = 1'($urandom);
            bus8.sub = 1'($urandom);
        end
        bus8.in_valid = 1'b0;
        chk({tag, ".latency"}, 32'(lat), 32'd8);
        chk({tag, ".sum"}, 32'(bus8.sum), 32'(es));
        chk({tag, ".cout"}, 32'(bus8.cout), 32'(ec));
        chk({tag, ".ovf"}, 32'(bus8.ovf), 32'(eo));
        if (release_it) begin
            bus8.out_ready = 1'b1;
            @(negedge clk);
            bus8.out_ready = 1'b0;
            chk({tag, ".out_valid_clr"}, 32'(bus8.out_valid), 32'd0);
            chk({tag, ".in_ready_ret"}, 32'(bus8.in_ready), 32'd1);
        end
    endtask

    initial begin
        logic [5:0] e;
        int l1, l2, l4;
        bit seen;

        rst_n = 1'b0;
        bus8.in_valid = 1'b1;  bus8.a = 8'hAA; bus8.b = 8'h55; bus8.cin = 1'b1;
        bus8.sub = 1'b0;       bus8.out_ready = 1'b0;
        bus41.in_valid = 1'b0; bus41.a = '0; bus41.b = '0; bus41.cin = 1'b0;
        bus41.sub = 1'b0;      bus41.out_ready = 1'b0;
        bus42.in_valid = 1'b0; bus42.a = '0; bus42.b = '0; bus42.cin = 1'b0;
        bus42.sub = 1'b0;      bus42.out_ready = 1'b0;
        bus44.in_valid = 1'b0; bus44.a = '0; bus44.b = '0; bus44.cin = 1'b0;
        bus44.sub = 1'b0;      bus44.out_ready = 1'b0;

        // Reset held three edges with in_valid asserted.
        repeat (3) begin
            @(negedge clk);
            chk("rst.in_ready", 32'(bus8.in_ready), 32'd0);
            chk("rst.out_valid", 32'(bus8.out_valid), 32'd0);
            chk("rst.sum", 32'(bus8.sum), 32'd0);
            chk("rst.cout", 32'(bus8.cout), 32'd0);
            chk("rst.ovf", 32'(bus8.ovf), 32'd0);
        end
        rst_n = 1'b1;
        bus8.in_valid = 1'b0;
        #1;
        chk("rst.in_ready_release", 32'(bus8.in_ready), 32'd1);

        op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        op8("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1);
        op8("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b1);
        op8("sub_10_0f", 8'h10, 8'h0F, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);

        // Backpressure on a signed-overflow add.
        op8("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        repeat (5) begin
            @(negedge clk);
            chk("bp.out_valid", 32'(bus8.out_valid), 32'd1);
            chk("bp.in_ready", 32'(bus8.in_ready), 32'd0);
            chk("bp.sum", 32'(bus8.sum), 32'h80);
            chk("bp.cout", 32'(bus8.cout), 32'd0);
            chk("bp.ovf", 32'(bus8.ovf), 32'd1);
        end
        bus8.out_ready = 1'b1;
        @(negedge clk);
        bus8.out_ready = 1'b0;
        chk("bp.out_valid_clr", 32'(bus8.out_valid), 32'd0);
        chk("bp.in_ready_ret", 32'(bus8.in_ready), 32'd1);
        chk("bp.sum_kept", 32'(bus8.sum), 32'h80);

        // Reset on the edge that would process slice 3.
        bus8.in_valid = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.cin = 1'b1; bus8.sub = 1'b0;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst.in_ready", 32'(bus8.in_ready), 32'd1);
        chk("midrst.out_valid", 32'(bus8.out_valid), 32'd0);
        chk("midrst.sum", 32'(bus8.sum), 32'd0);
        chk("midrst.cout", 32'(bus8.cout), 32'd0);
        chk("midrst.ovf", 32'(bus8.ovf), 32'd0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus8.out_valid) seen = 1'b1;
        end
        chk("midrst.no_valid", 32'(seen), 32'd0);
        op8("add_12_34", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);

        // Exhaustive 4-bit sweep across three slice widths in lockstep.
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    for (int si = 0; si < 2; si++) begin
                        bus41.a = 4'(ai); bus41.b = 4'(bi); bus41.cin = 1'(ci); bus41.sub = 1'(si);
                        bus42.a = 4'(ai); bus42.b = 4'(bi); bus42.cin = 1'(ci); bus42.sub = 1'(si);
                        bus44.a = 4'(ai); bus44.b = 4'(bi); bus44.cin = 1'(ci); bus44.sub = 1'(si);
                        bus41.in_valid = 1'b1;
                        bus42.in_valid = 1'b1;
                        bus44.in_valid = 1'b1;
                        @(negedge clk);
                        bus41.in_valid = 1'b0;
                        bus42.in_valid = 1'b0;
                        bus44.in_valid = 1'b0;
                        l1 = -1;
                        l2 = -1;
                        l4 = -1;
                        for (int t = 0; t < 8; t++) begin
                            if (l1 < 0 && bus41.out_valid) l1 = t;
                            if (l2 < 0 && bus42.out_valid) l2 = t;
                            if (l4 < 0 && bus44.out_valid) l4 = t;
                            if (l1 >= 0 && l2 >= 0 && l4 >= 0) break;
                            @(negedge clk);
                        end
                        e = ref4(4'(ai), 4'(bi), 1'(ci), 1'(si));
                        chk("x4b1.latency", 32'(l1), 32'd4);
                        chk("x4b2.latency", 32'(l2), 32'd2);
                        chk("x4b4.latency", 32'(l4), 32'd1);
                        chk("x4b1.sum", 32'(bus41.sum), 32'(e[3:0]));
                        chk("x4b2.sum", 32'(bus42.sum), 32'(e[3:0]));
                        chk("x4b4.sum", 32'(bus44.sum), 32'(e[3:0]));
                        chk("x4b1.cout", 32'(bus41.cout), 32'(e[4]));
                        chk("x4b2.cout", 32'(bus42.cout), 32'(e[4]));
                        chk("x4b4.cout", 32'(bus44.cout), 32'(e[4]));
                        chk("x4b1.ovf", 32'(bus41.ovf), 32'(e[5]));
                        chk("x4b2.ovf", 32'(bus42.ovf), 32'(e[5]));
                        chk("x4b4.ovf", 32'(bus44.ovf), 32'(e[5]));
                        bus41.out_ready = 1'b1;
                        bus42.out_ready = 1'b1;
                        bus44.out_ready = 1'b1;
                        @(negedge clk);
                        bus41.out_ready = 1'b0;
                        bus42.out_ready = 1'b0;
                        bus44.out_ready = 1'b0;
                    end
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
